// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds the 10-bit word boundary from control-token runs,
// then decodes pixel data, display enable and control bits with a fixed 2-clock pipeline.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS    = 16,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       hdmi_clk,
  input  logic       reset_n,
  input  logic [9:0] tmds_word,
  output logic [7:0] data_out,
  output logic       de_out,
  output logic [1:0] ctrl_out,
  output logic       locked,
  output logic [3:0] word_offset,
  output logic       token_seen
);

  localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
  localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_TOKENS);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SEARCH_TIMEOUT);
  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_TIMEOUT);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
  localparam logic [LOSS_W-1:0] LOSS_ONE = LOSS_W'(1);
  localparam logic [RUN_W-1:0]  RUN_ZERO  = RUN_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
  localparam logic [LOSS_W-1:0] LOSS_ZERO = LOSS_W'(0);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Returns {is_token, c1, c0} for the four TMDS control tokens.
  function automatic logic [2:0] token_match(input logic [9:0] q);
    logic [2:0] r;
    case (q)
      10'h354: r = 3'b100;
      10'h0AB: r = 3'b101;
      10'h154: r = 3'b110;
      10'h2AB: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d = q[9] ? ~q[7:0] : q[7:0];
    o = 8'h00;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  logic [9:0]        word_r;
  logic [9:0]        win_r;
  logic [19:0]       cat_s;
  logic [9:0]        win_nxt_s;
  logic [2:0]        match_s;
  logic              tok_s;
  logic [1:0]        tok_ctrl_s;
  logic [7:0]        dec_s;
  state_t            state_r;
  logic [RUN_W-1:0]  run_r;
  logic [IDLE_W-1:0] idle_r;
  logic [LOSS_W-1:0] loss_r;
  logic [RUN_W-1:0]  run_inc_s;
  logic [IDLE_W-1:0] idle_inc_s;
  logic [LOSS_W-1:0] loss_inc_s;
  logic              settle_r;
  logic [3:0]        offset_r;
  logic [3:0]        offset_inc_s;
  logic              locked_r;
  logic              lock_nxt_s;
  logic [7:0]        data_r;
  logic              de_r;
  logic [1:0]        ctrl_r;
  logic              token_r;

  // Window extraction: bit 0 of the older word is the earliest, so shifting right
  // by the offset slides the window later into the stream.
  always_comb begin
    cat_s     = {tmds_word, word_r};
    win_nxt_s = 10'h000;
    for (int i = 0; i < 10; i++) begin
      win_nxt_s[i] = cat_s[5'(i) + {1'b0, offset_r}];
    end
  end

  // Token classification, data decode and saturating counter increments.
  always_comb begin
    match_s      = token_match(win_r);
    tok_s        = match_s[2];
    tok_ctrl_s   = match_s[1:0];
    dec_s        = tmds_decode(win_r);
    run_inc_s    = (run_r == RUN_MAX) ? run_r : run_r + RUN_ONE;
    idle_inc_s   = (idle_r == IDLE_MAX) ? idle_r : idle_r + IDLE_ONE;
    loss_inc_s   = (loss_r == LOSS_MAX) ? loss_r : loss_r + LOSS_ONE;
    offset_inc_s = (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
  end

  // Lock state after this edge; output gating follows it so locked and forcing move together.
  always_comb begin
    lock_nxt_s = 1'b0;
    if (state_r == ST_LOCKED) begin
      lock_nxt_s = tok_s || (loss_inc_s != LOSS_MAX);
    end else if (settle_r) begin
      lock_nxt_s = 1'b0;
    end else begin
      lock_nxt_s = tok_s && (run_inc_s == RUN_MAX);
    end
  end

  // Two-stage input pipeline: raw word, then the offset-aligned window.
  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      word_r <= 10'h000;
      win_r  <= 10'h000;
    end else begin
      word_r <= tmds_word;
      win_r  <= win_nxt_s;
    end
  end

  // Alignment FSM: searches offsets on token runs, holds lock until tokens stop.
  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_SEARCH;
      run_r    <= RUN_ZERO;
      idle_r   <= IDLE_ZERO;
      loss_r   <= LOSS_ZERO;
      settle_r <= 1'b0;
      offset_r <= 4'd0;
      locked_r <= 1'b0;
    end else begin
      case (state_r)
        ST_SEARCH: begin
          loss_r <= LOSS_ZERO;
          if (settle_r) begin
            // window still holds a word aligned with the previous offset
            run_r    <= RUN_ZERO;
            idle_r   <= IDLE_ZERO;
            settle_r <= 1'b0;
          end else if (tok_s) begin
            idle_r <= IDLE_ZERO;
            if (run_inc_s == RUN_MAX) begin
              state_r  <= ST_LOCKED;
              locked_r <= 1'b1;
              run_r    <= RUN_ZERO;
            end else begin
              run_r <= run_inc_s;
            end
          end else if (idle_inc_s == IDLE_MAX) begin
            run_r    <= RUN_ZERO;
            idle_r   <= IDLE_ZERO;
            settle_r <= 1'b1;
            offset_r <= offset_inc_s;
          end else begin
            run_r  <= RUN_ZERO;
            idle_r <= idle_inc_s;
          end
        end
        ST_LOCKED: begin
          run_r    <= RUN_ZERO;
          idle_r   <= IDLE_ZERO;
          settle_r <= 1'b0;
          if (tok_s) begin
            loss_r <= LOSS_ZERO;
          end else if (loss_inc_s == LOSS_MAX) begin
            state_r  <= ST_SEARCH;
            locked_r <= 1'b0;
            loss_r   <= LOSS_ZERO;
          end else begin
            loss_r <= loss_inc_s;
          end
        end
        default: begin
          state_r  <= ST_SEARCH;
          run_r    <= RUN_ZERO;
          idle_r   <= IDLE_ZERO;
          loss_r   <= LOSS_ZERO;
          settle_r <= 1'b0;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  // Output register: decoded data while locked, forced idle otherwise.
  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r  <= 8'h00;
      de_r    <= 1'b0;
      ctrl_r  <= 2'b00;
      token_r <= 1'b0;
    end else begin
      token_r <= tok_s;
      if (!lock_nxt_s) begin
        data_r <= 8'h00;
        de_r   <= 1'b0;
        ctrl_r <= 2'b00;
      end else if (tok_s) begin
        data_r <= 8'h00;
        de_r   <= 1'b0;
        ctrl_r <= tok_ctrl_s;
      end else begin
        data_r <= dec_s;
        de_r   <= 1'b1;
      end
    end
  end

  assign data_out    = data_r;
  assign de_out      = de_r;
  assign ctrl_out    = ctrl_r;
  assign locked      = locked_r;
  assign word_offset = offset_r;
  assign token_seen  = token_r;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed scenarios plus randomized
// phase-shifted streams checked every cycle against a behavioural reference model.
module tb_tmds_channel_decoder;

  localparam int LOCK_N   = 16;
  localparam int SEARCH_N = 64;
  localparam int LOSS_N   = 128;

  logic       hdmi_clk  = 1'b0;
  logic       reset_n   = 1'b1;
  logic [9:0] tmds_word = 10'h000;
  logic [7:0] data_out;
  logic       de_out;
  logic [1:0] ctrl_out;
  logic       locked;
  logic [3:0] word_offset;
  logic       token_seen;

  tmds_channel_decoder #(
    .LOCK_TOKENS   (LOCK_N),
    .SEARCH_TIMEOUT(SEARCH_N),
    .LOSS_TIMEOUT  (LOSS_N)
  ) dut (
    .hdmi_clk   (hdmi_clk),
    .reset_n    (reset_n),
    .tmds_word  (tmds_word),
    .data_out   (data_out),
    .de_out     (de_out),
    .ctrl_out   (ctrl_out),
    .locked     (locked),
    .word_offset(word_offset),
    .token_seen (token_seen)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: plain integers, the stream history and the current window.
  int         m_prev, m_win, m_off, m_run, m_idle, m_loss;
  bit         m_locked, m_settle;
  int         exp_data, exp_ctrl;
  bit         exp_de, exp_tok;
  int         tx_prev;
  int         sb_q[$];
  logic [9:0] token_words [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit tok_lookup(input int w, output int c);
    c = 0;
    for (int k = 0; k < 4; k++) begin
      if (w == int'(token_words[k])) begin
        c = k;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int ref_decode(input int q);
    int d, o;
    d = ((q >> 9) & 1) != 0 ? (~q) & 255 : q & 255;
    o = (d ^ (d << 1)) & 255;
    if (((q >> 8) & 1) == 0) o = o ^ 254;
    return o;
  endfunction

  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [8:0] q;
    int         ones;
    bit         use_xnor;
    ones     = $countones(d);
    use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q        = 9'h000;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_win = 0; m_off = 0; m_run = 0; m_idle = 0; m_loss = 0;
    m_locked = 1'b0; m_settle = 1'b0;
    exp_data = 0; exp_ctrl = 0; exp_de = 1'b0; exp_tok = 1'b0;
    tx_prev = 0;
  endtask

  task automatic model_step(input int w);
    int c, nwin;
    bit tk;
    nwin = ((w * 1024 + m_prev) >> m_off) & 1023;
    tk   = tok_lookup(m_win, c);
    if (m_locked) begin
      if (tk) m_loss = 0;
      else begin
        m_loss++;
        if (m_loss == LOSS_N) begin m_locked = 1'b0; m_loss = 0; end
      end
    end else if (m_settle) begin
      m_settle = 1'b0; m_run = 0; m_idle = 0;
    end else if (tk) begin
      m_idle = 0;
      m_run++;
      if (m_run == LOCK_N) begin m_locked = 1'b1; m_run = 0; m_loss = 0; end
    end else begin
      m_run = 0;
      m_idle++;
      if (m_idle == SEARCH_N) begin m_off = (m_off + 1) % 10; m_idle = 0; m_settle = 1'b1; end
    end
    exp_tok = tk;
    if (!m_locked) begin
      exp_data = 0; exp_de = 1'b0; exp_ctrl = 0;
    end else if (tk) begin
      exp_data = 0; exp_de = 1'b0; exp_ctrl = c;
    end else begin
      exp_data = ref_decode(m_win); exp_de = 1'b1;
    end
    m_win  = nwin;
    m_prev = w;
  endtask

  task automatic check_outputs();
    chk("data_out", 32'(data_out), 32'(exp_data));
    chk("de_out", 32'(de_out), 32'(exp_de));
    chk("ctrl_out", 32'(ctrl_out), 32'(exp_ctrl));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("word_offset", 32'(word_offset), 32'(m_off));
    chk("token_seen", 32'(token_seen), 32'(exp_tok));
  endtask

  task automatic step(input logic [9:0] w);
    tmds_word = w;
    @(posedge hdmi_clk);
    model_step(int'(w));
    cyc++;
    #1;
    check_outputs();
  endtask

  // Transmit word tx over a link whose deserializer is shifted by ph bits.
  task automatic send_tx(input int tx, input int ph);
    int rx;
    rx = (ph == 0) ? tx : (((tx * 1024 + tx_prev) >> (10 - ph)) & 1023);
    tx_prev = tx;
    step(10'(rx));
  endtask

  task automatic sweep_word(input logic [9:0] w, input int b);
    int e;
    sb_q.push_back(b);
    step(w);
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front();
      if (e >= 0) chk("t6_byte", 32'(data_out), 32'(e));
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    tmds_word = 10'h000;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge hdmi_clk);
    @(negedge hdmi_clk);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  initial begin
    int         off_cyc [4];
    int         last_off, nd, ph, kind, len, tk;
    logic [8:0] qm;
    logic [9:0] w;

    #2;
    do_reset();

    // 1: aligned lock and decode
    for (int i = 1; i <= 24; i++) begin
      if (i <= 20) step(10'h354);
      else if (i == 21) step(10'h100);
      else if (i == 22) step(10'h2FF);
      else step(10'h354);
      if (cyc == 17) chk("t1_nolock17", 32'(locked), 32'd0);
      if (cyc == 18) begin
        chk("t1_lock18", 32'(locked), 32'd1);
        chk("t1_off", 32'(word_offset), 32'd0);
        chk("t1_ctrl", 32'(ctrl_out), 32'd0);
        chk("t1_de_tok", 32'(de_out), 32'd0);
      end
      if (cyc == 23) begin
        chk("t1_d00", 32'(data_out), 32'h00);
        chk("t1_de00", 32'(de_out), 32'd1);
      end
      if (cyc == 24) begin
        chk("t1_dFE", 32'(data_out), 32'hFE);
        chk("t1_deFE", 32'(de_out), 32'd1);
      end
    end

    // 2: misaligned search, 3-bit phase shift
    do_reset();
    off_cyc  = '{-1, -1, -1, -1};
    last_off = 0;
    for (int i = 1; i <= 215; i++) begin
      send_tx(10'h2AB, 3);
      if (int'(word_offset) != last_off && int'(word_offset) <= 3) off_cyc[word_offset] = cyc;
      last_off = int'(word_offset);
      if (cyc == 210) chk("t2_nolock210", 32'(locked), 32'd0);
      if (cyc == 211) begin
        chk("t2_lock211", 32'(locked), 32'd1);
        chk("t2_ctrl", 32'(ctrl_out), 32'd3);
      end
    end
    chk("t2_off1_at", 32'(off_cyc[1]), 32'd64);
    chk("t2_off2_at", 32'(off_cyc[2]), 32'd129);
    chk("t2_off3_at", 32'(off_cyc[3]), 32'd194);
    chk("t2_off_final", 32'(word_offset), 32'd3);

    // 5: async reset between edges while locked, carrying data
    send_tx(10'h2FF, 3);
    send_tx(10'h2AB, 3);
    send_tx(10'h2AB, 3);
    chk("t5_pre_de", 32'(de_out), 32'd1);
    chk("t5_pre_data", 32'(data_out), 32'hFE);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_locked", 32'(locked), 32'd0);
    chk("t5_de", 32'(de_out), 32'd0);
    chk("t5_data", 32'(data_out), 32'd0);
    chk("t5_ctrl", 32'(ctrl_out), 32'd0);
    chk("t5_offset", 32'(word_offset), 32'd0);
    do_reset();

    // 3: broken run, then 4: loss of lock
    for (int i = 1; i <= 180; i++) begin
      if (i <= 15) step(10'h354);
      else if (i == 16) step(10'h100);
      else if (i <= 48) step(10'h0AB);
      else step(10'h100);
      if (cyc == 33) chk("t3_nolock33", 32'(locked), 32'd0);
      if (cyc == 34) begin
        chk("t3_lock34", 32'(locked), 32'd1);
        chk("t3_ctrl", 32'(ctrl_out), 32'd1);
      end
      if (cyc == 177) begin
        chk("t4_lock177", 32'(locked), 32'd1);
        chk("t4_de177", 32'(de_out), 32'd1);
      end
      if (cyc == 178) begin
        chk("t4_unlock178", 32'(locked), 32'd0);
        chk("t4_de178", 32'(de_out), 32'd0);
        chk("t4_off", 32'(word_offset), 32'd0);
      end
      if (cyc == 180) chk("t4_de180", 32'(de_out), 32'd0);
    end

    // 6: decode sweep through a behavioural TMDS encoder, both polarities
    do_reset();
    repeat (20) step(10'h154);
    sb_q.delete();
    nd = 0;
    for (int b = 0; b < 256; b++) begin
      for (int p = 0; p < 2; p++) begin
        qm = tmds_qm(8'(b));
        w  = (p != 0) ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
        if (!tok_lookup(int'(w), tk)) begin
          sweep_word(w, b);
          nd++;
          if (nd % 32 == 0) sweep_word(10'h354, -1);
        end
      end
    end
    sweep_word(10'h354, -1);
    sweep_word(10'h354, -1);
    chk("t6_still_locked", 32'(locked), 32'd1);

    // randomized bursty streams at random deserializer phases
    for (int r = 0; r < 3; r++) begin
      do_reset();
      ph = $urandom_range(0, 9);
      while (cyc < 1500) begin
        kind = $urandom_range(0, 9);
        if (kind < 5) begin
          len = $urandom_range(10, 40);
          tk  = $urandom_range(0, 3);
          for (int k = 0; k < len; k++) send_tx(int'(token_words[tk]), ph);
        end else if (kind < 9) begin
          len = $urandom_range(1, 30);
          for (int k = 0; k < len; k++) send_tx($urandom_range(0, 1023), ph);
        end else begin
          len = $urandom_range(100, 160);
          for (int k = 0; k < len; k++) send_tx($urandom_range(0, 1023), ph);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
